// File: rtl/cond_logic_pkg.sv
// Shared types for the conditional-execution unit: condition codes and NZCV bit positions.
package cond_logic_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_logic_check.sv
// Condition evaluator: decides whether the instruction executes, from cond and the stored NZCV flags.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v, ge;

    assign n  = flags[FLAG_N];
    assign z  = flags[FLAG_Z];
    assign c  = flags[FLAG_C];
    assign v  = flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        cond_ex = 1'b1;
        case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = ge;
            LT: cond_ex = ~ge;
            GT: cond_ex = ~z & ge;
            LE: cond_ex = z | ~ge;
            // NV has no meaning in this core; execute it like AL rather than propagate X
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// ARM conditional-execution unit: holds NZCV, evaluates cond and gates the decoder's side-effect enables.
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pcs,
    input  logic       reg_w3,
    input  logic       reg_w1,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic [1:0] flag_w,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    output logic       pc_src,
    output logic       reg_write3,
    output logic       reg_write1,
    output logic       mem_write,
    output logic       carry
);

    logic       cond_ex;
    logic [1:0] flag_write;
    logic [1:0] flags_nz;
    logic [1:0] flags_cv;
    logic [3:0] flags;
    logic       n, z, c, v;

    assign flags = {flags_nz, flags_cv};
    assign n     = flags[FLAG_N];
    assign z     = flags[FLAG_Z];
    assign c     = flags[FLAG_C];
    assign v     = flags[FLAG_V];

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign flag_write = flag_w & {2{cond_ex}};

    // cond_ex is computed from the pre-edge flags, so an instruction never sees its own result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_nz <= 2'b00;
        else if (flag_write[1])
            flags_nz <= alu_flags[FLAG_N:FLAG_Z];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_cv <= 2'b00;
        else if (flag_write[0])
            flags_cv <= alu_flags[FLAG_C:FLAG_V];
    end

    assign pc_src     = pcs & cond_ex;
    assign mem_write  = mem_w & cond_ex;
    assign reg_write3 = reg_w3 & cond_ex & ~no_write;
    assign reg_write1 = reg_w1 & cond_ex & ~no_write;
    assign carry      = c;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic: gating, carry, every condition code, split writes, async reset.
module tb_cond_logic;
    import cond_logic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       pcs, reg_w3, reg_w1, mem_w, no_write;
    logic [1:0] flag_w;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic       pc_src, reg_write3, reg_write1, mem_write, carry;

    int checks = 0;
    int errors = 0;

    cond_logic dut (
        .clk        (clk),
        .reset      (reset),
        .pcs        (pcs),
        .reg_w3     (reg_w3),
        .reg_w1     (reg_w1),
        .mem_w      (mem_w),
        .no_write   (no_write),
        .flag_w     (flag_w),
        .cond       (cond),
        .alu_flags  (alu_flags),
        .pc_src     (pc_src),
        .reg_write3 (reg_write3),
        .reg_write1 (reg_write1),
        .mem_write  (mem_write),
        .carry      (carry)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not reach summary (observed running, required finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load all four flags via an AL instruction writing both groups.
    task automatic load_flags(input logic [3:0] f);
        cond      = AL;
        flag_w    = 2'b11;
        alu_flags = f;
        tick();
        flag_w    = 2'b00;
        alu_flags = 4'b0000;
    endtask

    task automatic cond_case(input cond_e cc, input logic [3:0] f, input logic exp);
        load_flags(f);
        pcs  = 1'b1;
        cond = cc;
        #1;
        check($sformatf("cond_%s_%b", cc.name(), f), {3'b000, dut.cond_ex}, {3'b000, exp});
        check($sformatf("pcsrc_%s_%b", cc.name(), f), {3'b000, pc_src}, {3'b000, exp});
        pcs  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pcs = 0; reg_w3 = 0; reg_w1 = 0; mem_w = 0; no_write = 0;
        flag_w = 2'b00; cond = AL; alu_flags = 4'b0000;
        #12;
        check("reset_flags", dut.flags, 4'b0000);
        check("reset_carry", {3'b000, carry}, 4'b0000);
        reset = 1'b1;
        tick();

        // gating with AL: {pc_src, reg_write3, reg_write1, mem_write}
        check("gate_all_off", {pc_src, reg_write3, reg_write1, mem_write}, 4'b0000);
        pcs = 1; #1; check("gate_pcs", {pc_src, reg_write3, reg_write1, mem_write}, 4'b1000);
        pcs = 0; reg_w3 = 1; #1; check("gate_w3", {pc_src, reg_write3, reg_write1, mem_write}, 4'b0100);
        reg_w3 = 0; reg_w1 = 1; #1; check("gate_w1", {pc_src, reg_write3, reg_write1, mem_write}, 4'b0010);
        reg_w1 = 0; mem_w = 1; #1; check("gate_mem", {pc_src, reg_write3, reg_write1, mem_write}, 4'b0001);
        mem_w = 0; reg_w3 = 1; reg_w1 = 1; no_write = 1; #1;
        check("gate_nowrite", {pc_src, reg_write3, reg_write1, mem_write}, 4'b0000);
        reg_w3 = 0; reg_w1 = 0; no_write = 0;

        // carry export
        load_flags(4'b0000);
        check("carry_0", {3'b000, carry}, 4'b0000);
        load_flags(4'b0010);
        check("carry_1", {3'b000, carry}, 4'b0001);

        // latency: flags written this cycle are not seen until after the edge
        load_flags(4'b0000);
        cond = EQ; flag_w = 2'b11; alu_flags = 4'b0100; #1;
        check("latency_pre", {3'b000, dut.cond_ex}, 4'b0000);
        // EQ fails with old flags, so this write is suppressed
        tick();
        check("latency_suppressed", dut.flags, 4'b0000);
        cond = AL; tick();
        flag_w = 2'b00; cond = EQ; #1;
        check("latency_post", {3'b000, dut.cond_ex}, 4'b0001);
        check("latency_flags", dut.flags, 4'b0100);

        // per-condition passes
        cond_case(EQ, 4'b0100, 1); cond_case(EQ, 4'b0000, 0);
        cond_case(NE, 4'b0000, 1); cond_case(NE, 4'b0100, 0);
        cond_case(CS, 4'b0010, 1); cond_case(CS, 4'b0000, 0);
        cond_case(CC, 4'b0000, 1); cond_case(CC, 4'b0010, 0);
        cond_case(MI, 4'b1000, 1); cond_case(MI, 4'b0000, 0);
        cond_case(PL, 4'b0000, 1); cond_case(PL, 4'b1000, 0);
        cond_case(VS, 4'b0001, 1); cond_case(VS, 4'b0000, 0);
        cond_case(VC, 4'b0000, 1); cond_case(VC, 4'b0001, 0);
        cond_case(HI, 4'b0010, 1); cond_case(HI, 4'b0110, 0); cond_case(HI, 4'b0000, 0);
        cond_case(LS, 4'b0100, 1); cond_case(LS, 4'b0000, 1); cond_case(LS, 4'b0010, 0);
        cond_case(GE, 4'b1001, 1); cond_case(GE, 4'b0000, 1); cond_case(GE, 4'b1000, 0);
        cond_case(LT, 4'b0001, 1); cond_case(LT, 4'b1000, 1); cond_case(LT, 4'b1001, 0);
        cond_case(GT, 4'b1001, 1); cond_case(GT, 4'b0000, 1); cond_case(GT, 4'b0100, 0);
        cond_case(GT, 4'b1000, 0);
        cond_case(LE, 4'b0100, 1); cond_case(LE, 4'b0001, 1); cond_case(LE, 4'b1000, 1);
        cond_case(LE, 4'b0000, 0); cond_case(LE, 4'b1001, 0);
        cond_case(AL, 4'b1111, 1); cond_case(AL, 4'b0000, 1);
        cond_case(NV, 4'b0000, 1);

        // failed condition: no side effects and no flag update
        load_flags(4'b0100);
        cond = NE; pcs = 1; reg_w3 = 1; reg_w1 = 1; mem_w = 1;
        flag_w = 2'b11; alu_flags = 4'b1011; #1;
        check("fail_gated", {pc_src, reg_write3, reg_write1, mem_write}, 4'b0000);
        tick();
        check("fail_no_update", dut.flags, 4'b0100);
        pcs = 0; reg_w3 = 0; reg_w1 = 0; mem_w = 0; flag_w = 2'b00;

        // split group writes
        load_flags(4'b1111);
        cond = AL; flag_w = 2'b01; alu_flags = 4'b0000;
        tick();
        check("split_cv", dut.flags, 4'b1100);
        check("split_cv_carry", {3'b000, carry}, 4'b0000);
        flag_w = 2'b10;
        tick();
        check("split_nz", dut.flags, 4'b0000);
        flag_w = 2'b00;

        // asynchronous reset mid-cycle
        load_flags(4'b0110);
        check("pre_reset_flags", dut.flags, 4'b0110);
        cond = EQ; #1;
        check("pre_reset_eq", {3'b000, dut.cond_ex}, 4'b0001);
        reset = 1'b0; #1;
        check("async_flags", dut.flags, 4'b0000);
        check("async_carry", {3'b000, carry}, 4'b0000);
        check("async_eq", {3'b000, dut.cond_ex}, 4'b0000);
        cond = NE; #1;
        check("async_ne", {3'b000, dut.cond_ex}, 4'b0001);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
